// File: rtl/i2c_master_seq_if.sv
// i2c_master_seq_if: host/phase-generator/pin bundle for the I2C bit/byte sequencer
//   master modport (sequencer side):
//     in : data_clk, switch_range, ena, addr, rw, wr_data, sda_in
//     out: scl_not_ena, sda_oe, busy, wr_req, rd_data, rd_valid, ack_err
//   slave modport (host/phase generator/pin side): the same signals, reversed
interface i2c_master_seq_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              data_clk;
    logic              switch_range;
    logic              ena;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic              sda_in;
    logic              scl_not_ena;
    logic              sda_oe;
    logic              busy;
    logic              wr_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ack_err;

    modport master (
        input  data_clk, switch_range, ena, addr, rw, wr_data, sda_in,
        output scl_not_ena, sda_oe, busy, wr_req, rd_data, rd_valid, ack_err
    );

    modport slave (
        output data_clk, switch_range, ena, addr, rw, wr_data, sda_in,
        input  scl_not_ena, sda_oe, busy, wr_req, rd_data, rd_valid, ack_err
    );
endinterface

// File: rtl/i2c_master_seq.sv
// i2c_master_seq: I2C master bit/byte sequencer (START, addr+R/W, ACK, data, Sr, STOP)
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : i2c_master_seq_if.master -- phase inputs (data_clk, switch_range),
//              host command (ena, addr, rw, wr_data), pin (sda_in, sda_oe, scl_not_ena),
//              status (busy, wr_req, rd_data, rd_valid, ack_err); all outputs registered
module i2c_master_seq #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input logic clk,
    input logic rst,
    i2c_master_seq_if.master bus
);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [3:0] {IDLE, START, ADDR, ACK1, WR, RD, MACK, ACK2, STOP} state_t;

    state_t            state, state_d;
    logic              dc_q, sw_q;
    logic [ADDR_W:0]   addr_rw, addr_rw_d;
    logic [DATA_W-1:0] wdat, wdat_d, sh, sh_d, rd_d;
    logic [BW-1:0]     cnt, cnt_d, cnt_m1;
    logic              scl_d, sda_d, busy_d, wr_req_d, rv_d, err_d;
    logic              dc_rise, smp, same;

    assign dc_rise = bus.data_clk & ~dc_q;
    assign smp     = bus.switch_range & ~sw_q;
    assign cnt_m1  = cnt - BW'(1);
    // "same" = host wants to keep talking to the slave currently addressed
    assign same    = bus.ena && ({bus.addr, bus.rw} == addr_rw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            dc_q            <= 1'b0;
            sw_q            <= 1'b0;
            addr_rw         <= '0;
            wdat            <= '0;
            sh              <= '0;
            cnt             <= '0;
            bus.scl_not_ena <= 1'b1;
            bus.sda_oe      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.wr_req      <= 1'b0;
            bus.rd_data     <= '0;
            bus.rd_valid    <= 1'b0;
            bus.ack_err     <= 1'b0;
        end else begin
            state           <= state_d;
            dc_q            <= bus.data_clk;
            sw_q            <= bus.switch_range;
            addr_rw         <= addr_rw_d;
            wdat            <= wdat_d;
            sh              <= sh_d;
            cnt             <= cnt_d;
            bus.scl_not_ena <= scl_d;
            bus.sda_oe      <= sda_d;
            bus.busy        <= busy_d;
            bus.wr_req      <= wr_req_d;
            bus.rd_data     <= rd_d;
            bus.rd_valid    <= rv_d;
            bus.ack_err     <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        addr_rw_d = addr_rw;
        wdat_d    = wdat;
        sh_d      = sh;
        cnt_d     = cnt;
        scl_d     = bus.scl_not_ena;
        sda_d     = bus.sda_oe;
        busy_d    = bus.busy;
        wr_req_d  = 1'b0;
        rd_d      = bus.rd_data;
        rv_d      = 1'b0;
        err_d     = bus.ack_err;
        // sampling looks at the state before any same-cycle transition
        if (smp) begin
            if ((state == ACK1 || state == ACK2) && bus.sda_in) err_d = 1'b1;
            if (state == RD) sh_d = {sh[DATA_W-2:0], bus.sda_in};
        end
        if (dc_rise) begin
            case (state)
                IDLE: if (bus.ena) begin
                    addr_rw_d = {bus.addr, bus.rw};
                    wdat_d    = bus.wr_data;
                    wr_req_d  = 1'b1;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    sda_d     = 1'b1;
                    state_d   = START;
                end
                START: begin
                    scl_d   = 1'b0;
                    cnt_d   = BW'(ADDR_W);
                    sda_d   = ~addr_rw[ADDR_W];
                    state_d = ADDR;
                end
                ADDR: begin
                    cnt_d   = (cnt != 0) ? cnt_m1 : cnt;
                    sda_d   = (cnt != 0) ? ~addr_rw[cnt_m1] : 1'b0;
                    state_d = (cnt != 0) ? ADDR : ACK1;
                end
                ACK1: begin
                    cnt_d   = BW'(DATA_W - 1);
                    sda_d   = addr_rw[0] ? 1'b0 : ~wdat[DATA_W-1];
                    state_d = addr_rw[0] ? RD : WR;
                end
                WR: begin
                    cnt_d   = (cnt != 0) ? cnt_m1 : cnt;
                    sda_d   = (cnt != 0) ? ~wdat[cnt_m1] : 1'b0;
                    state_d = (cnt != 0) ? WR : ACK2;
                end
                RD: begin
                    cnt_d   = (cnt != 0) ? cnt_m1 : cnt;
                    // master ACKs only if the host wants another byte from this slave
                    sda_d   = (cnt != 0) ? 1'b0 : same;
                    state_d = (cnt != 0) ? RD : MACK;
                    if (cnt == 0) begin
                        rd_d = sh;
                        rv_d = 1'b1;
                    end
                end
                ACK2, MACK: begin
                    if (same) begin
                        cnt_d   = BW'(DATA_W - 1);
                        state_d = (state == ACK2) ? WR : RD;
                        sda_d   = (state == ACK2) ? ~bus.wr_data[DATA_W-1] : 1'b0;
                        if (state == ACK2) begin
                            wdat_d   = bus.wr_data;
                            wr_req_d = 1'b1;
                        end
                    end else if (bus.ena) begin
                        // new target or direction: repeated START without STOP
                        addr_rw_d = {bus.addr, bus.rw};
                        wdat_d    = bus.wr_data;
                        wr_req_d  = 1'b1;
                        sda_d     = 1'b0;
                        state_d   = START;
                    end else begin
                        scl_d   = 1'b1;
                        sda_d   = 1'b1;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    sda_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_seq.sv
// tb_i2c_master_seq: directed bench for i2c_master_seq with sda_oe / rd_data scoreboards
module tb_i2c_master_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_seq_if #(.ADDR_W(7), .DATA_W(8)) bus();
    i2c_master_seq #(.ADDR_W(7), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr_req = 0;
    int n_rd = 0;
    logic       q_sda[$];
    logic [7:0] q_rd[$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) q_sda.push_back(~b[i]);
    endtask

    // one data_clk period: SDA change point, then SCL-high sample point
    task automatic period(input logic sdi);
        @(negedge clk);
        bus.data_clk = 1'b1;
        bus.sda_in   = sdi;
        @(negedge clk);
        if (q_sda.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sda_sb_empty: observed sda_oe %b with no expected entry", bus.sda_oe);
        end else chk1("sda_oe", bus.sda_oe, q_sda.pop_front());
        @(negedge clk);
        bus.data_clk = 1'b0;
        @(negedge clk);
        bus.switch_range = 1'b1;
        @(negedge clk);
        bus.switch_range = 1'b0;
    endtask

    task automatic write_txn(input logic [7:0] d, input logic ack1);
        int p;
        bus.addr = 7'h50; bus.rw = 1'b0; bus.wr_data = d; bus.ena = 1'b1;
        q_sda.push_back(1'b1);
        push_byte(8'hA0);
        q_sda.push_back(1'b0);
        push_byte(d);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b1);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b0);
        for (int i = 0; i < 20; i++) begin
            p = i + 1;
            period(p == 10 ? ack1 : (p == 19 ? 1'b0 : 1'b1));
            if (p == 1) begin
                chk1("busy_start", bus.busy, 1'b1);
                chk1("ack_err_clr", bus.ack_err, 1'b0);
                bus.ena = 1'b0;
            end
            if (p == 10) chk1("ack_err_ack1", bus.ack_err, ack1);
        end
        chk1("scl_stop", bus.scl_not_ena, 1'b1);
        chk1("busy_stop", bus.busy, 1'b1);
        bus.ena = 1'b1;
        period(1'b1);
        chk1("busy_idle", bus.busy, 1'b0);
        bus.ena = 1'b0;
        period(1'b1);
        chk1("busy_ena_ignored", bus.busy, 1'b0);
        chk1("scl_idle", bus.scl_not_ena, 1'b1);
        chk1("ack_err_sticky", bus.ack_err, ack1);
    endtask

    always @(negedge clk) begin
        if (bus.wr_req) n_wr_req++;
        if (bus.rd_valid) begin
            n_rd++;
            if (q_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_sb_empty: observed rd_data %h with no expected entry", bus.rd_data);
            end else chk8("rd_data", bus.rd_data, q_rd.pop_front());
        end
    end

    initial begin
        logic [7:0] rdb;
        int p, base;
        bus.data_clk = 1'b0; bus.switch_range = 1'b0; bus.ena = 1'b0;
        bus.addr = '0; bus.rw = 1'b0; bus.wr_data = '0; bus.sda_in = 1'b1;
        repeat (2) @(negedge clk);
        chk1("rst_scl", bus.scl_not_ena, 1'b1);
        chk1("rst_sda", bus.sda_oe, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_wr_req", bus.wr_req, 1'b0);
        chk1("rst_rd_valid", bus.rd_valid, 1'b0);
        chk8("rst_rd_data", bus.rd_data, 8'h00);
        chk1("rst_ack_err", bus.ack_err, 1'b0);
        rst = 1'b0;

        // reset in the middle of a write data byte
        bus.addr = 7'h50; bus.rw = 1'b0; bus.wr_data = 8'hA5; bus.ena = 1'b1;
        q_sda.push_back(1'b1);
        push_byte(8'hA0);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b1);
        for (int i = 0; i < 12; i++) begin
            period(i == 9 ? 1'b0 : 1'b1);
            if (i == 0) bus.ena = 1'b0;
        end
        chk1("midwr_busy", bus.busy, 1'b1);
        chk1("midwr_scl", bus.scl_not_ena, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("arst_scl", bus.scl_not_ena, 1'b1);
        chk1("arst_sda", bus.sda_oe, 1'b0);
        chk1("arst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // plain write with ACK, then address NACK
        base = n_wr_req;
        write_txn(8'hA5, 1'b0);
        chk8("wr_req_count", 8'(n_wr_req - base), 8'd1);
        write_txn(8'h3C, 1'b1);

        // two-byte read: master ACK after byte 1, NACK + STOP after byte 2
        rdb = 8'h3C;
        base = n_rd;
        bus.addr = 7'h50; bus.rw = 1'b1; bus.ena = 1'b1;
        q_rd.push_back(8'h3C);
        q_rd.push_back(8'h3C);
        q_sda.push_back(1'b1);
        push_byte(8'hA1);
        q_sda.push_back(1'b0);
        repeat (8) q_sda.push_back(1'b0);
        q_sda.push_back(1'b1);
        repeat (8) q_sda.push_back(1'b0);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b1);
        q_sda.push_back(1'b0);
        for (int i = 0; i < 30; i++) begin
            p = i + 1;
            if (p == 28) bus.ena = 1'b0;
            period(p == 10 ? 1'b0 :
                   (p >= 11 && p <= 18) ? rdb[7 - (p - 11)] :
                   (p >= 20 && p <= 27) ? rdb[7 - (p - 20)] : 1'b1);
            if (p == 1) chk1("rd_ack_err_clr", bus.ack_err, 1'b0);
        end
        chk8("rd_valid_count", 8'(n_rd - base), 8'd2);
        chk1("rd_busy_end", bus.busy, 1'b0);

        // write, then switch to read with ena held: repeated START, no STOP
        bus.addr = 7'h50; bus.rw = 1'b0; bus.wr_data = 8'h11; bus.ena = 1'b1;
        q_sda.push_back(1'b1);
        push_byte(8'hA0);
        q_sda.push_back(1'b0);
        push_byte(8'h11);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b0);
        q_sda.push_back(1'b1);
        for (int i = 0; i < 22; i++) begin
            p = i + 1;
            if (p == 20) bus.rw = 1'b1;
            period((p == 10 || p == 19) ? 1'b0 : 1'b1);
            if (p >= 20) begin
                chk1("sr_busy", bus.busy, 1'b1);
                chk1("sr_scl", bus.scl_not_ena, 1'b0);
            end
        end
        bus.ena = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        chk8("sda_sb_left", 8'(q_sda.size()), 8'd0);
        chk8("rd_sb_left", 8'(q_rd.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
